dac081s101_tx: RTL and testbench

//  SPI-style transmitter for a TI DAC081S101 8-bit DAC; the write-side counterpart of the adc081s101 receiver.

---
 rtl/imaging_pkg.sv | 32 +++
 rtl/dac081s101_tx.sv | 125 ++++++++++++
 tb/tb_dac081s101_tx.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/imaging_pkg.sv
`default_nettype none
// imaging_pkg: shared encodings for the imaging subsystem DAC transmitter.
// Rev 1.0
package imaging_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_SETUP = 4'd1,
    ST_LOW   = 4'd2,
    ST_HIGH  = 4'd3,
    ST_STOP  = 4'd4
  } state_e;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  localparam int PD_MSB   = 13;
  localparam int DATA_MSB = 11;

  // Frame layout {2'b00, pd, data, 4'b0000}, transmitted bit 15 first.
  function automatic logic [15:0] frame_word(input logic [1:0] pd, input logic [7:0] data);
    logic [15:0] w;
    w = '0;
    w[PD_MSB -: 2]   = pd;
    w[DATA_MSB -: 8] = data;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dac081s101_tx.sv
`default_nettype none
// dac081s101_tx: serialises (pd, code) words into 16-bit DAC081S101 SYNC/SCLK/DIN frames.
// Rev 1.0
module dac081s101_tx
  import imaging_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int SYNC_IDLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic [1:0] wr_pd,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       dac_sync_n,
  output logic       dac_sclk,
  output logic       dac_din,
  output logic       busy,
  output logic       done,
  output logic [3:0] tp_state
);

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] IDLE_LAST = 8'(SYNC_IDLE - 1);

  state_e      state, state_nxt;
  logic [7:0]  div_cnt, div_nxt;
  logic [3:0]  bit_cnt;
  logic [15:0] shifter;
  logic        full;
  logic [1:0]  hold_pd;
  logic [7:0]  hold_data;
  logic        launch;
  logic [15:0] frame;

  assign frame    = frame_word(hold_pd, hold_data);
  assign wr_ready = ~full;
  assign busy     = (state != ST_IDLE) | full;
  assign tp_state = state;

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (full) begin
          state_nxt = ST_SETUP;
          launch    = 1'b1;
        end
      end
      ST_SETUP: if (div_cnt == DIV_LAST) state_nxt = ST_LOW;
      ST_LOW:   if (div_cnt == DIV_LAST) state_nxt = (bit_cnt == 4'd0) ? ST_STOP : ST_HIGH;
      ST_HIGH:  if (div_cnt == DIV_LAST) state_nxt = ST_LOW;
      ST_STOP: begin
        // A word accepted during the gap chains straight into the next frame.
        if (div_cnt == IDLE_LAST) begin
          if (full) begin
            state_nxt = ST_SETUP;
            launch    = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    div_nxt = ((state_nxt != state) || (state == ST_IDLE)) ? 8'd0 : div_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      div_cnt    <= 8'd0;
      bit_cnt    <= 4'd0;
      shifter    <= 16'd0;
      full       <= 1'b0;
      hold_pd    <= 2'b00;
      hold_data  <= 8'd0;
      dac_sync_n <= 1'b1;
      dac_sclk   <= 1'b1;
      dac_din    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      done    <= (state == ST_LOW) && (state_nxt == ST_STOP);

      if (launch) begin
        full <= 1'b0;
      end else if (wr_valid && !full) begin
        full      <= 1'b1;
        hold_pd   <= wr_pd;
        hold_data <= wr_data;
      end

      if (launch) begin
        shifter    <= frame;
        bit_cnt    <= 4'd15;
        dac_sync_n <= 1'b0;
        dac_sclk   <= 1'b1;
        dac_din    <= frame[15];
      end else if (state_nxt != state) begin
        case (state_nxt)
          ST_LOW: dac_sclk <= 1'b0;
          ST_HIGH: begin
            // Data moves on the rising edge so it is stable around the next fall.
            dac_sclk <= 1'b1;
            dac_din  <= shifter[14];
            shifter  <= {shifter[14:0], 1'b0};
            bit_cnt  <= bit_cnt - 4'd1;
          end
          ST_STOP: begin
            dac_sclk   <= 1'b1;
            dac_sync_n <= 1'b1;
            dac_din    <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dac081s101_tx.sv
`default_nettype none
// tb_dac081s101_tx: directed vectors against a pin-level DAC capture model, two parameter sets.
// Rev 1.0
module tb_dac081s101_tx;
  import imaging_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] wr_valid = 2'b00;
  logic [1:0] pd_a = 2'b00, pd_b = 2'b00;
  logic [7:0] data_a = 8'd0, data_b = 8'd0;
  logic [1:0] wr_ready, sync_n, sclk, din, busy, done;
  logic [3:0] tp_a, tp_b;

  always #5 clk = ~clk;

  dac081s101_tx #(.CLK_DIV(4), .SYNC_IDLE(2)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid[0]), .wr_pd(pd_a), .wr_data(data_a),
    .wr_ready(wr_ready[0]), .dac_sync_n(sync_n[0]), .dac_sclk(sclk[0]), .dac_din(din[0]),
    .busy(busy[0]), .done(done[0]), .tp_state(tp_a));

  dac081s101_tx #(.CLK_DIV(1), .SYNC_IDLE(1)) dut_fast (
    .clk(clk), .reset(reset), .wr_valid(wr_valid[1]), .wr_pd(pd_b), .wr_data(data_b),
    .wr_ready(wr_ready[1]), .dac_sync_n(sync_n[1]), .dac_sclk(sclk[1]), .dac_din(din[1]),
    .busy(busy[1]), .done(done[1]), .tp_state(tp_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DAC capture model: shifts din on every sclk fall while sync_n is low.
  logic [15:0] words [2][16];
  int          falls_r [2][16];
  int          low_r   [2][16];
  int          fall_c  [2][16];
  int          rise_c  [2][16];
  int          nfr [2] = '{0, 0};
  int          ndone [2] = '{0, 0};
  int          cur_falls [2] = '{0, 0};
  int          cur_low [2] = '{0, 0};
  logic [15:0] acc [2];
  logic [1:0]  in_fr = 2'b00, prev_sync = 2'b11, prev_sclk = 2'b11;

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (done[u]) ndone[u]++;
      if (!reset) begin
        in_fr[u] = 1'b0;
      end else begin
        if (!sync_n[u] && prev_sync[u]) begin
          in_fr[u] = 1'b1; acc[u] = 16'd0; cur_falls[u] = 0; cur_low[u] = 0;
          if (nfr[u] < 16) fall_c[u][nfr[u]] = cyc;
        end
        if (in_fr[u] && !sync_n[u]) begin
          cur_low[u]++;
          if (prev_sclk[u] && !sclk[u]) begin
            acc[u] = {acc[u][14:0], din[u]};
            cur_falls[u]++;
          end
        end
        if (in_fr[u] && sync_n[u] && !prev_sync[u]) begin
          if (nfr[u] < 16) begin
            words[u][nfr[u]] = acc[u]; falls_r[u][nfr[u]] = cur_falls[u];
            low_r[u][nfr[u]] = cur_low[u]; rise_c[u][nfr[u]] = cyc;
          end
          nfr[u]++;
          in_fr[u] = 1'b0;
        end
      end
      prev_sync[u] = sync_n[u];
      prev_sclk[u] = sclk[u];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input int u, input logic [1:0] pd, input logic [7:0] d, output int acc_cyc);
    int n;
    @(negedge clk);
    wr_valid[u] = 1'b1;
    if (u == 0) begin pd_a = pd; data_a = d; end
    else        begin pd_b = pd; data_b = d; end
    n = 0;
    while (!wr_ready[u] && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) check("send_timeout", 32'(n), 32'd0);
    acc_cyc = cyc;
    @(posedge clk);
    #1 wr_valid[u] = 1'b0;
  endtask

  task automatic wait_frames(input int u, input int target);
    int n;
    n = 0;
    while (nfr[u] < target && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) check("frame_timeout", 32'(nfr[u]), 32'(target));
  endtask

  int a, b, d0, n;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sync_n", 32'(sync_n[0]), 32'd1);
    check("rst_sclk", 32'(sclk[0]), 32'd1);
    check("rst_din", 32'(din[0]), 32'd0);
    check("rst_ready", 32'(wr_ready[0]), 32'd1);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_done", 32'(done[0]), 32'd0);
    check("rst_tp", 32'(tp_a), 32'(ST_IDLE));
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single write, pd=00 data=A5
    b = nfr[0]; d0 = ndone[0];
    send(0, PD_NORMAL, 8'hA5, a);
    wait_frames(0, b + 1);
    check("t2_word", 32'(words[0][b]), 32'h0A50);
    check("t2_falls", 32'(falls_r[0][b]), 32'd16);
    check("t2_low", 32'(low_r[0][b]), 32'd128);
    check("t2_latency", 32'(fall_c[0][b] - a), 32'd2);
    repeat (4) @(negedge clk);
    check("t2_done", 32'(ndone[0] - d0), 32'd1);
    check("t2_ready", 32'(wr_ready[0]), 32'd1);
    check("t2_busy", 32'(busy[0]), 32'd0);

    // pd=11 data=FF
    check("t3_sclk_pre", 32'(sclk[0]), 32'd1);
    b = nfr[0];
    send(0, PD_HIZ, 8'hFF, a);
    wait_frames(0, b + 1);
    check("t3_word", 32'(words[0][b]), 32'h3FF0);
    repeat (4) @(negedge clk);
    check("t3_sclk_post", 32'(sclk[0]), 32'd1);
    check("t3_tp", 32'(tp_a), 32'(ST_IDLE));

    // Back-to-back with a stalled third write
    b = nfr[0]; d0 = ndone[0];
    send(0, PD_NORMAL, 8'h01, a);
    send(0, PD_NORMAL, 8'h02, a);
    @(negedge clk);
    check("t4_stall_ready", 32'(wr_ready[0]), 32'd0);
    check("t4_stall_busy", 32'(busy[0]), 32'd1);
    send(0, PD_1K, 8'h03, a);
    wait_frames(0, b + 3);
    check("t4_w1", 32'(words[0][b]), 32'h0010);
    check("t4_w2", 32'(words[0][b+1]), 32'h0020);
    check("t4_w3", 32'(words[0][b+2]), 32'h1030);
    check("t4_gap1", 32'(fall_c[0][b+1] - rise_c[0][b]), 32'd2);
    check("t4_gap2", 32'(fall_c[0][b+2] - rise_c[0][b+1]), 32'd2);
    check("t4_period", 32'(fall_c[0][b+1] - fall_c[0][b]), 32'd130);
    repeat (4) @(negedge clk);
    check("t4_done", 32'(ndone[0] - d0), 32'd3);

    // Reset mid-frame after 7 sclk falls
    b = nfr[0]; d0 = ndone[0];
    send(0, PD_NORMAL, 8'h55, a);
    n = 0;
    while (!(in_fr[0] && cur_falls[0] == 7) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) check("t5_wait_timeout", 32'(n), 32'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    check("t5_sync_n", 32'(sync_n[0]), 32'd1);
    check("t5_sclk", 32'(sclk[0]), 32'd1);
    check("t5_din", 32'(din[0]), 32'd0);
    check("t5_ready", 32'(wr_ready[0]), 32'd1);
    check("t5_busy", 32'(busy[0]), 32'd0);
    check("t5_tp", 32'(tp_a), 32'(ST_IDLE));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (200) @(negedge clk);
    check("t5_no_done", 32'(ndone[0] - d0), 32'd0);
    check("t5_no_frame", 32'(nfr[0] - b), 32'd0);
    send(0, PD_NORMAL, 8'h3C, a);
    wait_frames(0, b + 1);
    check("t5_word", 32'(words[0][b]), 32'h03C0);
    check("t5_falls", 32'(falls_r[0][b]), 32'd16);

    // CLK_DIV=1, SYNC_IDLE=1 continuous stream
    b = nfr[1];
    send(1, PD_NORMAL, 8'h81, a);
    send(1, PD_NORMAL, 8'h7E, a);
    send(1, PD_100K, 8'h00, a);
    send(1, PD_HIZ, 8'hC3, a);
    wait_frames(1, b + 4);
    check("t6_w0", 32'(words[1][b]), 32'h0810);
    check("t6_w1", 32'(words[1][b+1]), 32'h07E0);
    check("t6_w2", 32'(words[1][b+2]), 32'h2000);
    check("t6_w3", 32'(words[1][b+3]), 32'h3C30);
    for (int k = 0; k < 4; k++) begin
      check("t6_falls", 32'(falls_r[1][b+k]), 32'd16);
      check("t6_low", 32'(low_r[1][b+k]), 32'd32);
    end
    for (int k = 0; k < 3; k++)
      check("t6_period", 32'(fall_c[1][b+k+1] - fall_c[1][b+k]), 32'd33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
